fc_sequencer: RTL and testbench

- Time-multiplexed controller for the fully-connected stage. It replaces the flat 1152x10 combinational dot product with a single multiply-accumulate unit that is sequenced over the inputs.
- Reads pooled activations from the pool buffer and weights from the weight ROM, one pair per cycle, both synchronous 1-cycle-latency memories.
- Emits one saturated class score per class and a running argmax.
- Sits between the pooling stage (start) and the classifier output logic (done, results).

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_mac.sv | 48 ++++
 rtl/fc_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_fc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected stage sequencer: datapath widths,
// FSM state encoding and the output saturation helper.
package fc_pkg;

  localparam int unsigned DATA_W    = 45;   // unsigned pooled activation
  localparam int unsigned WEIGHT_W  = 32;   // signed weight / bias
  localparam int unsigned OUT_W     = 32;   // signed class score
  localparam int unsigned N_IN_MAX  = 1152; // largest supported inputs per class
  localparam int unsigned PROD_W    = WEIGHT_W + DATA_W + 1;
  // Headroom for N_IN_MAX products, so the accumulator can never overflow.
  localparam int unsigned ACC_W     = PROD_W + $clog2(N_IN_MAX);

  localparam logic signed [OUT_W-1:0] SCORE_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] SCORE_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } fc_state_t;

  // Clamp an accumulator-width value into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    // The value fits when every bit above the result sign bit matches it.
    if (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}}) begin
      r = v[OUT_W-1:0];
    end else if (v[ACC_W-1]) begin
      r = SCORE_MIN;
    end else begin
      r = SCORE_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Registered signed multiply-accumulate used by fc_sequencer.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears the accumulator)
//   clr_i        synchronous clear (wins over en_i)
//   en_i         add a_i * w_i into the accumulator this cycle
//   a_i          unsigned activation, treated as non-negative
//   w_i          signed weight
//   acc_o        accumulator value
module fc_mac
  import fc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic [DATA_W-1:0]          a_i,
  input  logic signed [WEIGHT_W-1:0] w_i,
  output logic signed [ACC_W-1:0]    acc_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  // Zero-extend the activation by one bit so it multiplies as a positive signed value.
  assign prod = PROD_W'(w_i) * PROD_W'($signed({1'b0, a_i}));

  // Next accumulator value.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_sequencer.sv
// Time-multiplexed fully-connected stage: walks the pool buffer and weight ROM
// one pair per cycle through a single MAC, emits one saturated score per class
// and tracks the running argmax (ties keep the lower class index).
// Optional feature macro: FC_BIAS_EN adds a per-class bias memory (b_addr/b_data)
// whose value is added to the accumulator before shifting and saturation.
// Ports:
//   clk, rst_n             clock, async active-low reset (aborts a run)
//   start                  one-cycle request, accepted only when idle
//   busy                   high while a run is in progress
//   pool_addr / pool_data  activation memory, 1-cycle read latency
//   w_addr / w_data        weight memory (class*N_IN + idx), 1-cycle latency
//   b_addr / b_data        bias memory (FC_BIAS_EN only), 1-cycle latency
//   res_valid              one-cycle pulse per class with res_class / res_data
//   argmax                 best class so far, final when done pulses
//   done                   one-cycle pulse after the last class
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned N_IN      = 1152,
  parameter int unsigned N_CLASS   = 10,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic [$clog2(N_IN)-1:0]             pool_addr,
  input  logic [DATA_W-1:0]                   pool_data,
  output logic [$clog2(N_IN*N_CLASS)-1:0]     w_addr,
  input  logic signed [WEIGHT_W-1:0]          w_data,
`ifdef FC_BIAS_EN
  output logic [$clog2(N_CLASS)-1:0]          b_addr,
  input  logic signed [WEIGHT_W-1:0]          b_data,
`endif
  output logic                                res_valid,
  output logic [$clog2(N_CLASS)-1:0]          res_class,
  output logic signed [OUT_W-1:0]             res_data,
  output logic [$clog2(N_CLASS)-1:0]          argmax,
  output logic                                done
);

  localparam int unsigned PA_W = $clog2(N_IN);
  localparam int unsigned WA_W = $clog2(N_IN*N_CLASS);
  localparam int unsigned CL_W = $clog2(N_CLASS);

  fc_state_t               state_d, state_q;
  logic [CL_W-1:0]         cls_d, cls_q;
  logic [PA_W-1:0]         idx_d, idx_q;
  logic [WA_W-1:0]         waddr_d, waddr_q;
  logic                    rd_valid_d, rd_valid_q;
  logic                    busy_d, busy_q;
  logic                    res_valid_d, res_valid_q;
  logic [CL_W-1:0]         res_class_d, res_class_q;
  logic signed [OUT_W-1:0] res_data_d, res_data_q;
  logic [CL_W-1:0]         argmax_d, argmax_q;
  logic signed [OUT_W-1:0] best_d, best_q;
  logic                    done_d, done_q;
`ifdef FC_BIAS_EN
  logic [CL_W-1:0]         baddr_d, baddr_q;
`endif

  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_biased;
  logic signed [ACC_W-1:0] acc_shifted;
  logic signed [OUT_W-1:0] score;
  logic                    last_idx;
  logic                    last_cls;

  // Accumulator starts clean for every run and every class.
  assign mac_clr = ((state_q == IDLE) && start) || (state_q == WRITE);

  fc_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (rd_valid_q),
    .a_i   (pool_data),
    .w_i   (w_data),
    .acc_o (acc)
  );

  // Class score as seen during WRITE.
`ifdef FC_BIAS_EN
  assign acc_biased = acc + ACC_W'(b_data);
`else
  assign acc_biased = acc;
`endif
  assign acc_shifted = acc_biased >>> OUT_SHIFT;
  assign score       = saturate(acc_shifted);

  assign last_idx = (idx_q == PA_W'(N_IN - 1));
  assign last_cls = (cls_q == CL_W'(N_CLASS - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    idx_d       = idx_q;
    waddr_d     = waddr_q;
    rd_valid_d  = 1'b0;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_class_d = res_class_q;
    res_data_d  = res_data_q;
    argmax_d    = argmax_q;
    best_d      = best_q;
    done_d      = 1'b0;
`ifdef FC_BIAS_EN
    baddr_d     = baddr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cls_d    = '0;
          idx_d    = '0;
          waddr_d  = '0;
          busy_d   = 1'b1;
          best_d   = SCORE_MIN;
          argmax_d = '0;
`ifdef FC_BIAS_EN
          baddr_d  = '0;
`endif
        end
      end

      RUN: begin
        // Address issued this cycle returns data next cycle.
        rd_valid_d = 1'b1;
        if (last_idx) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + PA_W'(1);
          waddr_d = waddr_q + WA_W'(1);
        end
      end

      DRAIN: begin
        state_d = WRITE;
      end

      WRITE: begin
        res_valid_d = 1'b1;
        res_class_d = cls_q;
        res_data_d  = score;
        if (score > best_q) begin
          best_d   = score;
          argmax_d = cls_q;
        end
        idx_d = '0;
        if (last_cls) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          cls_d   = cls_q + CL_W'(1);
          waddr_d = waddr_q + WA_W'(1);
`ifdef FC_BIAS_EN
          baddr_d = cls_q + CL_W'(1);
`endif
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cls_q       <= '0;
      idx_q       <= '0;
      waddr_q     <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_data_q  <= '0;
      argmax_q    <= '0;
      best_q      <= '0;
      done_q      <= 1'b0;
`ifdef FC_BIAS_EN
      baddr_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      idx_q       <= idx_d;
      waddr_q     <= waddr_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_data_q  <= res_data_d;
      argmax_q    <= argmax_d;
      best_q      <= best_d;
      done_q      <= done_d;
`ifdef FC_BIAS_EN
      baddr_q     <= baddr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign pool_addr = idx_q;
  assign w_addr    = waddr_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_data  = res_data_q;
  assign argmax    = argmax_q;
  assign done      = done_q;
`ifdef FC_BIAS_EN
  assign b_addr    = baddr_q;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// Self-checking bench for fc_sequencer with N_IN=4, N_CLASS=3: directed table
// vectors, start-while-busy, reset mid-run, and randomized runs against a
// dot-product reference model.
module tb_fc_sequencer;

  localparam int N_IN      = 4;
  localparam int N_CLASS   = 3;
  localparam int OUT_SHIFT = 0;
  localparam int DW        = 45;
  localparam int WW        = 32;
  localparam int OW        = 32;
  localparam int PER       = N_IN + 2;
  localparam int DONE_CYC  = N_CLASS * PER + 1;
  localparam int NW        = N_IN * N_CLASS;

  typedef struct packed {
    logic [N_IN-1:0][DW-1:0]    pool;
    logic [NW-1:0][WW-1:0]      w;
    logic [N_CLASS-1:0][WW-1:0] b;
    logic [N_CLASS-1:0][OW-1:0] score;
    logic [1:0]                 amax;
  } vec_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic [1:0]           pool_addr;
  logic [DW-1:0]        pool_data;
  logic [3:0]           w_addr;
  logic signed [WW-1:0] w_data;
  logic                 res_valid;
  logic [1:0]           res_class;
  logic signed [OW-1:0] res_data;
  logic [1:0]           argmax;
  logic                 done;
`ifdef FC_BIAS_EN
  logic [1:0]           b_addr;
  logic signed [WW-1:0] b_data;
`endif

  logic [DW-1:0]        pool_mem [N_IN];
  logic signed [WW-1:0] w_mem    [NW];
  logic signed [WW-1:0] b_mem    [N_CLASS];

  int n_checks = 0;
  int n_fail   = 0;

  fc_sequencer #(
    .N_IN      (N_IN),
    .N_CLASS   (N_CLASS),
    .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .pool_addr (pool_addr),
    .pool_data (pool_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
`ifdef FC_BIAS_EN
    .b_addr    (b_addr),
    .b_data    (b_data),
`endif
    .res_valid (res_valid),
    .res_class (res_class),
    .res_data  (res_data),
    .argmax    (argmax),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    pool_data <= pool_mem[pool_addr];
    w_data    <= w_mem[w_addr];
`ifdef FC_BIAS_EN
    b_data    <= b_mem[b_addr];
`endif
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: per-class dot product, optional bias, shift, clamp; argmax is
  // the first index holding the maximum score.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    logic signed [127:0]  s;
    logic signed [127:0]  wv;
    logic signed [127:0]  pv;
    logic signed [WW-1:0] wt;
    logic signed [OW-1:0] sc [N_CLASS];
    int am;
    r = v;
    for (int c = 0; c < N_CLASS; c++) begin
      s = '0;
      for (int i = 0; i < N_IN; i++) begin
        wt = v.w[c*N_IN + i];
        wv = 128'(wt);
        pv = 128'(v.pool[i]);
        s  = s + wv * pv;
      end
`ifdef FC_BIAS_EN
      wt = v.b[c];
      s  = s + 128'(wt);
`endif
      s = s >>> OUT_SHIFT;
      if (s > 128'sd2147483647)       sc[c] = 32'sh7FFFFFFF;
      else if (s < -128'sd2147483648) sc[c] = 32'sh80000000;
      else                            sc[c] = s[31:0];
      r.score[c] = sc[c];
    end
    am = 0;
    for (int c = 1; c < N_CLASS; c++) begin
      if (sc[c] > sc[am]) am = c;
    end
    r.amax = 2'(am);
    return r;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < N_IN; i++)    pool_mem[i] = v.pool[i];
    for (int i = 0; i < NW; i++)      w_mem[i]    = v.w[i];
    for (int i = 0; i < N_CLASS; i++) b_mem[i]    = v.b[i];
  endtask

  // One full run; checks pulse timing, class, score, done timing and argmax.
  task automatic run_vec(input vec_t v, input int second_start, input string tag);
    int nval;
    int ndone;
    nval  = 0;
    ndone = 0;
    load(v);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'(1));
    for (int cyc = 1; cyc <= DONE_CYC + 3; cyc++) begin
      start = (cyc == second_start);
      @(posedge clk);
      #1;
      if (res_valid) begin
        if (nval < N_CLASS) begin
          check($sformatf("%s_res%0d_cycle", tag, nval), 64'(cyc), 64'((nval + 1) * PER));
          check($sformatf("%s_res%0d_class", tag, nval), 64'(res_class), 64'(nval));
          check($sformatf("%s_res%0d_data", tag, nval), 64'(res_data),
                64'($signed(v.score[nval])));
        end
        nval++;
      end
      if (done) begin
        ndone++;
        check({tag, "_done_cycle"}, 64'(cyc), 64'(DONE_CYC));
        check({tag, "_argmax"}, 64'(argmax), 64'(v.amax));
        check({tag, "_busy_fall"}, 64'(busy), 64'(0));
      end
    end
    start = 1'b0;
    check({tag, "_n_res_valid"}, 64'(nval), 64'(N_CLASS));
    check({tag, "_n_done"}, 64'(ndone), 64'(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_done"},      64'(done),      64'(0));
    check({tag, "_res_class"}, 64'(res_class), 64'(0));
    check({tag, "_res_data"},  64'(res_data),  64'(0));
    check({tag, "_argmax"},    64'(argmax),    64'(0));
    check({tag, "_pool_addr"}, 64'(pool_addr), 64'(0));
    check({tag, "_w_addr"},    64'(w_addr),    64'(0));
  endtask

  vec_t vecs [6];
  int   n_vecs;
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N_IN; i++)    pool_mem[i] = '0;
    for (int i = 0; i < NW; i++)      w_mem[i]    = '0;
    for (int i = 0; i < N_CLASS; i++) b_mem[i]    = '0;

    // Directed vectors with hand-derived expectations.
    vecs[0] = '0;                       // functional run
    vecs[0].pool[0] = 45'd1; vecs[0].pool[1] = 45'd2;
    vecs[0].pool[2] = 45'd3; vecs[0].pool[3] = 45'd4;
    for (int i = 0; i < N_IN; i++) vecs[0].w[i] = 32'd1;
    vecs[0].w[4]  = -32'sd1;
    vecs[0].w[11] = 32'sd5;
    vecs[0].score[0] = 32'sd10; vecs[0].score[1] = -32'sd1; vecs[0].score[2] = 32'sd20;
    vecs[0].amax = 2'd2;

    vecs[1] = '0;                       // positive saturation
    vecs[1].pool[0] = {1'b1, 44'd0};
    vecs[1].w[0]    = 32'h7FFFFFFF;
    vecs[1].score[0] = 32'h7FFFFFFF;
    vecs[1].amax = 2'd0;

    vecs[2] = '0;                       // negative saturation; class 1 (0) beats MIN
    vecs[2].pool[0] = {1'b1, 44'd0};
    vecs[2].w[0]    = 32'h80000000;
    vecs[2].score[0] = 32'h80000000;
    vecs[2].amax = 2'd1;

    vecs[3] = '0;                       // all tie at 7
    vecs[3].pool[0] = 45'd7;
    vecs[3].w[0] = 32'd1; vecs[3].w[4] = 32'd1; vecs[3].w[8] = 32'd1;
    for (int c = 0; c < N_CLASS; c++) vecs[3].score[c] = 32'sd7;
    vecs[3].amax = 2'd0;

    vecs[4] = '0;                       // all tie at -5
    vecs[4].pool[0] = 45'd5;
    vecs[4].w[0] = -32'sd1; vecs[4].w[4] = -32'sd1; vecs[4].w[8] = -32'sd1;
    for (int c = 0; c < N_CLASS; c++) vecs[4].score[c] = -32'sd5;
    vecs[4].amax = 2'd0;
    n_vecs = 5;

`ifdef FC_BIAS_EN
    vecs[5] = vecs[0];                  // bias flips the winner to class 0
    vecs[5].b[0] = 32'sd100; vecs[5].b[1] = -32'sd100; vecs[5].b[2] = 32'sd0;
    vecs[5].score[0] = 32'sd110; vecs[5].score[1] = -32'sd101; vecs[5].score[2] = 32'sd20;
    vecs[5].amax = 2'd0;
    n_vecs = 6;
`endif

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table; the functional vector also gets an ignored start at cycle 3.
    for (int k = 0; k < n_vecs; k++) begin
      run_vec(vecs[k], (k == 0) ? 3 : -1, $sformatf("vec%0d", k));
    end

    // Abort mid-run, then a clean run must show no accumulator residue.
    load(vecs[0]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], -1, "after_rst");

    // Randomized runs against the reference model.
    for (int r = 0; r < 16; r++) begin
      rv = '0;
      for (int i = 0; i < N_IN; i++) begin
        if ((r % 4) == 3) rv.pool[i] = DW'({$urandom, $urandom});
        else              rv.pool[i] = DW'($urandom_range(0, 65535));
      end
      for (int i = 0; i < NW; i++) begin
        if ((r % 2) == 1) rv.w[i] = $urandom;
        else              rv.w[i] = WW'($signed(($urandom_range(0, 2000)) - 1000));
      end
`ifdef FC_BIAS_EN
      for (int c = 0; c < N_CLASS; c++) rv.b[c] = WW'($signed(($urandom_range(0, 200000)) - 100000));
`endif
      rv = ref_model(rv);
      run_vec(rv, -1, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
